trap_capture: RTL and testbench
===============================

// Module: trap_capture
// PURPOSE
//  Consumes the trap centre position and per-pixel draw requests. Detects ball/trap overlap once per frame.
//  On a hit, holds the ball on the trap for a fixed number of frames, then releases it and
//  runs a cooldown. Sits between the trap path generator and the ball physics/mux in the main screen.
// PARAMETERS
//  HOLD_FRAMES      120  frames ball stays captured (1..255)
//  COOLDOWN_FRAMES  60   frames after release during which hits are ignored (1..255)
//  BALL_HALF_SIZE   8    ball half-width in pixels; override = trap centre - this
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   reset, asynchronous, active-low
//  startOfFrame   in   1   one-cycle frame strobe
//  reset_level    in   1   synchronous level restart
//  pause          in   1   freeze timers/FSM, suppress hit detection
//  trapCenterX    in   11  current trap centre X
//  trapCenterY    in   11  current trap centre Y
//  ballDR         in   1   ball drawing request, current pixel
//  trapDR         in   1   trap drawing request, current pixel
//  captured       out  1   high while ball is held; physics must use override position
//  ballOverrideX  out  11  ball top-left X while captured
//  ballOverrideY  out  11  ball top-left Y while captured
//  releasePulse   out  1   one-cycle strobe on release (physics re-arms velocity)
//  captureCount   out  4   saturating number of captures since resetN
// BEHAVIOUR
//  Reset (resetN low): state IDLE; hit flag, timer, captureCount = 0; all outputs 0.
//  Hit flag: set in any cycle with ballDR && trapDR && !pause. Cleared on every startOfFrame.
//   If startOfFrame and overlap occur in the same cycle, the flag is evaluated and cleared first,
//   then set, so the overlap counts for the next frame.
//  FSM advances only on startOfFrame && !pause, using the flag value before clearing:
//   IDLE:     flag=1 -> CAPTURED; timer <= HOLD_FRAMES-1; captureCount++ (saturates at 15).
//   CAPTURED: timer==0 -> COOLDOWN; timer <= COOLDOWN_FRAMES-1; releasePulse=1 next cycle; else timer--.
//   COOLDOWN: flag ignored. timer==0 -> IDLE; else timer--.
//  Latency: overlap in frame N -> captured high the cycle after frame N+1's startOfFrame.
//   captured stays high for exactly HOLD_FRAMES frames.
//  ballOverride{X,Y}: registered every clk while CAPTURED as trapCenter - BALL_HALF_SIZE.
//   Saturates at 0 when the centre is below BALL_HALF_SIZE. Outputs 0 outside CAPTURED.
//  releasePulse: exactly one clk wide. Never asserted by reset_level.
//  pause: FSM, timer and outputs hold. Hit flag cleared on startOfFrame and not set while paused.
//  reset_level: takes priority over startOfFrame. Next cycle: IDLE, flag = 0, timer = 0,
//   captured = 0, overrides = 0. captureCount is retained. A capture in progress is aborted
//   without releasePulse.
// CONFIGURATION
//  TRAP_CAPTURE_COUNT_EN defined: captureCount operates as above.
//  Not defined: captureCount is tied to 0 and no counter register is built. All else unchanged.
// STRUCTURE
//  Package defines:
//   - typedef enum logic [1:0] {TRAP_IDLE, TRAP_CAPTURED, TRAP_COOLDOWN} trap_capture_state_t.
//   - default constants SCREEN_MAIN_TRAP_HOLD_FRAMES and SCREEN_MAIN_TRAP_COOLDOWN_FRAMES.
//   - SCREEN_MAIN_BALL_HALF_SIZE.
//  Sub-module frame_timer: 8-bit down counter with load/value and decrement on
//   (startOfFrame && !pause), plus a zero flag. Instantiated once and shared by the hold and
//   cooldown phases.
// TESTING (HOLD_FRAMES=3, COOLDOWN_FRAMES=2, BALL_HALF_SIZE=8, TRAP_CAPTURE_COUNT_EN defined)
//  1. Overlap pixel in frame 0, trap at (100,50):
//     -> captured rises after SOF 1, override = (92,42).
//     -> captured falls after SOF 4; releasePulse 1 clk; captureCount = 1.
//  2. Overlap every frame during cooldown:
//     -> no re-capture. The first overlap after returning to IDLE (SOF 6) captures at SOF 7.
//  3. pause held 5 frames mid-CAPTURED:
//     -> captured remains high. Hold ends 3 unpaused frames after entry.
//     -> Overlaps while paused do not register.
//  4. reset_level in CAPTURED:
//     -> next cycle captured = 0, overrides = 0, no releasePulse, captureCount unchanged.
//  5. Trap centre (4,3):
//     -> override (0,0).
//     -> 16 captures: captureCount stays at 15.
//  6. resetN asserted mid-CAPTURED:
//     -> all outputs 0 immediately (asynchronous).
//     -> after release, IDLE with captureCount 0.

Source files
------------

// File: rtl/trap_capture_pkg.sv
// Shared types and default constants for the trap capture block.
// Also holds the saturating coordinate-offset helper used for the ball override position.
package trap_capture_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_CAPTURED,
    TRAP_COOLDOWN
  } trap_capture_state_t;

  localparam int SCREEN_MAIN_TRAP_HOLD_FRAMES     = 120;
  localparam int SCREEN_MAIN_TRAP_COOLDOWN_FRAMES = 60;
  localparam int SCREEN_MAIN_BALL_HALF_SIZE       = 8;

  localparam int COORD_W = 11;
  localparam int TIMER_W = 8;
  localparam int COUNT_W = 4;

  // Ball top-left from trap centre, clamped at the screen edge instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/trap_capture_frame_timer.sv
// Frame-granular down counter shared by the hold and cooldown phases of trap_capture.
// Clear beats load beats decrement; the count rests at zero rather than wrapping.
module frame_timer
  import trap_capture_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic               is_zero
);

  logic [TIMER_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/trap_capture.sv
// Ball/trap overlap detector with frame-based hold and cooldown for the main screen.
// Optional feature: define TRAP_CAPTURE_COUNT_EN to build the saturating captureCount register.
module trap_capture
  import trap_capture_pkg::*;
#(
  parameter int HOLD_FRAMES     = SCREEN_MAIN_TRAP_HOLD_FRAMES,
  parameter int COOLDOWN_FRAMES = SCREEN_MAIN_TRAP_COOLDOWN_FRAMES,
  parameter int BALL_HALF_SIZE  = SCREEN_MAIN_BALL_HALF_SIZE
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               reset_level,
  input  logic               pause,
  input  logic [COORD_W-1:0] trapCenterX,
  input  logic [COORD_W-1:0] trapCenterY,
  input  logic               ballDR,
  input  logic               trapDR,
  output logic               captured,
  output logic [COORD_W-1:0] ballOverrideX,
  output logic [COORD_W-1:0] ballOverrideY,
  output logic               releasePulse,
  output logic [COUNT_W-1:0] captureCount
);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_FRAMES - 1);
  localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN_FRAMES - 1);
  localparam logic [COORD_W-1:0] HALF      = COORD_W'(BALL_HALF_SIZE);

  trap_capture_state_t state, state_next;
  logic               hit_flag;
  logic               frame_advance;
  logic               timer_zero;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               release_next;

  assign frame_advance = startOfFrame && !pause;

  frame_timer u_frame_timer (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (reset_level),
    .load       (timer_load),
    .load_value (timer_load_value),
    .tick       (frame_advance),
    .is_zero    (timer_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    timer_load       = 1'b0;
    timer_load_value = '0;
    release_next     = 1'b0;
    if (reset_level) begin
      state_next = TRAP_IDLE;
    end else if (frame_advance) begin
      unique case (state)
        TRAP_IDLE: begin
          if (hit_flag) begin
            state_next       = TRAP_CAPTURED;
            timer_load       = 1'b1;
            timer_load_value = HOLD_LOAD;
          end
        end
        TRAP_CAPTURED: begin
          if (timer_zero) begin
            state_next       = TRAP_COOLDOWN;
            timer_load       = 1'b1;
            timer_load_value = COOL_LOAD;
            release_next     = 1'b1;
          end
        end
        TRAP_COOLDOWN: begin
          if (timer_zero) state_next = TRAP_IDLE;
        end
        default: state_next = TRAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= TRAP_IDLE;
      releasePulse <= 1'b0;
    end else begin
      state        <= state_next;
      releasePulse <= release_next;
    end
  end

  // The frame strobe clears the old flag before this cycle's overlap can set it again.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_flag <= 1'b0;
    end else if (reset_level) begin
      hit_flag <= 1'b0;
    end else begin
      hit_flag <= (hit_flag && !startOfFrame) || (ballDR && trapDR && !pause);
    end
  end

  // Loaded from state_next so the override is valid in the first captured cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ballOverrideX <= '0;
      ballOverrideY <= '0;
    end else if (reset_level) begin
      ballOverrideX <= '0;
      ballOverrideY <= '0;
    end else if (!pause) begin
      if (state_next == TRAP_CAPTURED) begin
        ballOverrideX <= sat_sub(trapCenterX, HALF);
        ballOverrideY <= sat_sub(trapCenterY, HALF);
      end else begin
        ballOverrideX <= '0;
        ballOverrideY <= '0;
      end
    end
  end

  assign captured = (state == TRAP_CAPTURED);

`ifdef TRAP_CAPTURE_COUNT_EN
  logic               count_inc;
  logic [COUNT_W-1:0] capture_count_q;

  assign count_inc = !reset_level && frame_advance && (state == TRAP_IDLE) && hit_flag;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      capture_count_q <= '0;
    end else if (count_inc && (capture_count_q != '1)) begin
      capture_count_q <= capture_count_q + 1'b1;
    end
  end

  assign captureCount = capture_count_q;
`else
  assign captureCount = '0;
`endif

endmodule

// File: tb/tb_trap_capture.sv
// Self-checking bench for trap_capture: frame-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_trap_capture;
  import trap_capture_pkg::*;

  localparam int HOLD = 3;
  localparam int COOL = 2;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        reset_level = 1'b0;
  logic        pause = 1'b0;
  logic [10:0] trapCenterX = 11'd100;
  logic [10:0] trapCenterY = 11'd50;
  logic        ballDR = 1'b0;
  logic        trapDR = 1'b0;
  logic        captured;
  logic [10:0] ballOverrideX;
  logic [10:0] ballOverrideY;
  logic        releasePulse;
  logic [3:0]  captureCount;

  always #5 clk = ~clk;

  trap_capture #(
    .HOLD_FRAMES     (HOLD),
    .COOLDOWN_FRAMES (COOL),
    .BALL_HALF_SIZE  (HALF)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .reset_level   (reset_level),
    .pause         (pause),
    .trapCenterX   (trapCenterX),
    .trapCenterY   (trapCenterY),
    .ballDR        (ballDR),
    .trapDR        (trapDR),
    .captured      (captured),
    .ballOverrideX (ballOverrideX),
    .ballOverrideY (ballOverrideY),
    .releasePulse  (releasePulse),
    .captureCount  (captureCount)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_count(input int n);
`ifdef TRAP_CAPTURE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Frame-level model: mode 0 idle, 1 holding, 2 cooling; frames_left counts unpaused frame
  // strobes still to come in the current phase.
  int m_mode = 0, m_left = 0, m_count = 0, m_ovx = 0, m_ovy = 0;
  bit m_flag = 1'b0, m_rel = 1'b0;

  function automatic int clamp_sub(input int a);
    return (a > HALF) ? a - HALF : 0;
  endfunction

  task automatic model_step();
    bit prev_flag;
    m_rel = 1'b0;
    if (reset_level) begin
      m_mode = 0; m_left = 0; m_flag = 1'b0; m_ovx = 0; m_ovy = 0;
    end else begin
      prev_flag = m_flag;
      if (startOfFrame) m_flag = 1'b0;
      if (ballDR && trapDR && !pause) m_flag = 1'b1;
      if (startOfFrame && !pause) begin
        if (m_mode == 0) begin
          if (prev_flag) begin
            m_mode = 1; m_left = HOLD;
            if (m_count < 15) m_count++;
          end
        end else if (m_mode == 1) begin
          m_left--;
          if (m_left == 0) begin m_mode = 2; m_left = COOL; m_rel = 1'b1; end
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
      if (!pause) begin
        m_ovx = (m_mode == 1) ? clamp_sub(int'(trapCenterX)) : 0;
        m_ovy = (m_mode == 1) ? clamp_sub(int'(trapCenterY)) : 0;
      end
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_mode = 0; m_left = 0; m_count = 0; m_ovx = 0; m_ovy = 0; m_flag = 1'b0; m_rel = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_captured", captured, (m_mode == 1));
      check("model_override_x", ballOverrideX, m_ovx);
      check("model_override_y", ballOverrideY, m_ovy);
      check("model_release", releasePulse, m_rel);
      check("model_count", captureCount, exp_count(m_count));
    end
  end

  task automatic cyc(input bit s, input bit b, input bit t, input bit p, input bit r);
    startOfFrame = s; ballDR = b; trapDR = t; pause = p; reset_level = r;
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input bit p);
    cyc(1'b1, 1'b0, 1'b0, p, 1'b0);
  endtask

  // Frame body: lone ball pixel, optional overlap pixel, lone trap pixel.
  task automatic body(input bit ov, input bit p);
    cyc(1'b0, 1'b1, 1'b0, p, 1'b0);
    cyc(1'b0, ov, ov, p, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, p, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_capture();
    body(1'b1, 1'b0);
    sof(1'b0);
    repeat (5) begin
      body(1'b0, 1'b0);
      sof(1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_captured", captured, 0);
    check("reset_release", releasePulse, 0);
    check("reset_count", captureCount, 0);
    resetN = 1'b1;
    cmp_en = 1'b1;

    // Capture, hold, release.
    sof(1'b0); body(1'b1, 1'b0);
    sof(1'b0);
    check("t1_captured_rise", captured, 1);
    check("t1_override_x", ballOverrideX, 92);
    check("t1_override_y", ballOverrideY, 42);
    body(1'b0, 1'b0);
    sof(1'b0); body(1'b0, 1'b0);
    sof(1'b0); body(1'b0, 1'b0);
    sof(1'b0);
    check("t1_captured_fall", captured, 0);
    check("t1_release_high", releasePulse, 1);
    check("t1_count", captureCount, exp_count(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_release_one_clk", releasePulse, 0);

    // Overlap every frame during cooldown.
    body(1'b1, 1'b0);
    sof(1'b0); body(1'b1, 1'b0);
    sof(1'b0);
    check("t2_no_recapture", captured, 0);
    body(1'b1, 1'b0);
    sof(1'b0);
    check("t2_capture_sof7", captured, 1);
    check("t2_count", captureCount, exp_count(2));

    // Pause mid-hold with overlaps.
    body(1'b0, 1'b0);
    sof(1'b0); body(1'b0, 1'b0);
    repeat (5) begin
      sof(1'b1);
      check("t3_paused_held", captured, 1);
      body(1'b1, 1'b1);
    end
    sof(1'b0);
    check("t3_still_held", captured, 1);
    body(1'b0, 1'b0);
    sof(1'b0);
    check("t3_release_after_3", captured, 0);
    check("t3_release_pulse", releasePulse, 1);
    body(1'b0, 1'b0);
    sof(1'b0); body(1'b0, 1'b0);
    sof(1'b0); body(1'b1, 1'b1);
    sof(1'b0);
    check("t3_paused_overlap_ignored", captured, 0);

    // reset_level aborts a capture.
    body(1'b1, 1'b0);
    sof(1'b0);
    check("t4_captured", captured, 1);
    body(1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_rl_captured", captured, 0);
    check("t4_rl_override_x", ballOverrideX, 0);
    check("t4_rl_release", releasePulse, 0);
    check("t4_rl_count_kept", captureCount, exp_count(3));
    body(1'b0, 1'b0);
    sof(1'b0);
    check("t4_stays_idle", captured, 0);
    check("t4_no_release", releasePulse, 0);

    // Override clamps at zero; captureCount saturates.
    trapCenterX = 11'd4;
    trapCenterY = 11'd3;
    body(1'b1, 1'b0);
    sof(1'b0);
    check("t5_captured", captured, 1);
    check("t5_override_x_zero", ballOverrideX, 0);
    check("t5_override_y_zero", ballOverrideY, 0);
    repeat (5) begin
      body(1'b0, 1'b0);
      sof(1'b0);
    end
    repeat (12) do_capture();
    check("t5_count_16_caps", captureCount, exp_count(15));
    do_capture();
    check("t5_count_saturated", captureCount, exp_count(15));

    // Asynchronous reset mid-hold.
    trapCenterX = 11'd100;
    trapCenterY = 11'd50;
    body(1'b1, 1'b0);
    sof(1'b0);
    check("t6_captured", captured, 1);
    #2;
    resetN = 1'b0;
    #1;
    check("t6_async_captured", captured, 0);
    check("t6_async_override_x", ballOverrideX, 0);
    check("t6_async_override_y", ballOverrideY, 0);
    check("t6_async_release", releasePulse, 0);
    check("t6_async_count", captureCount, 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    body(1'b0, 1'b0);
    sof(1'b0);
    check("t6_idle_after", captured, 0);
    check("t6_count_zero", captureCount, 0);
    body(1'b1, 1'b0);
    sof(1'b0);
    check("t6_recapture", captured, 1);
    body(1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
